// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N weight-stationary systolic array: loads weight rows,
// pulses the weight switch, streams row-skewed input vectors, then drains.
module systolic_ctrl #(
  parameter int unsigned ARRAY_N    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned VEC_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [VEC_W-1:0]              i_num_vec,
  output logic                          o_busy,
  output logic                          o_done,
  input  logic                          i_w_valid,
  output logic                          o_w_ready,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] i_w_data,
  input  logic                          i_x_valid,
  output logic                          o_x_ready,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] i_x_data,
  output logic                          o_arr_enable,
  output logic [ARRAY_N*DATA_WIDTH-1:0] o_arr_weight,
  output logic [ARRAY_N-1:0]            o_arr_accept_w,
  output logic [ARRAY_N*DATA_WIDTH-1:0] o_arr_input,
  output logic [ARRAY_N-1:0]            o_arr_valid,
  output logic [ARRAY_N-1:0]            o_arr_switch,
  output logic [ARRAY_N-1:0]            o_res_valid
);

  localparam int unsigned WCntW = $clog2(ARRAY_N + 1);
  localparam int unsigned DCntW = $clog2(2 * ARRAY_N);

  typedef enum logic [2:0] {StIdle, StLoadW, StSwitch, StStream, StDrain} state_e;

  state_e             r_state, w_state_d;
  logic [WCntW-1:0]   r_wcnt;
  logic [VEC_W-1:0]   r_vcnt;
  logic [VEC_W-1:0]   r_num_vec;
  logic [DCntW-1:0]   r_dcnt;
  logic               r_done;
  logic [2*ARRAY_N-2:0] r_vchain;

  logic w_start_ok, w_w_hs, w_x_hs, w_last_w, w_last_x, w_drain_end;

  assign w_start_ok  = (r_state == StIdle) && i_start && (i_num_vec != '0);
  assign w_w_hs      = (r_state == StLoadW) && i_w_valid;
  assign w_x_hs      = (r_state == StStream) && i_x_valid;
  assign w_last_w    = w_w_hs && (r_wcnt == WCntW'(ARRAY_N - 1));
  assign w_last_x    = w_x_hs && (r_vcnt == r_num_vec - VEC_W'(1));
  assign w_drain_end = (r_state == StDrain) && (r_dcnt == DCntW'(2 * ARRAY_N - 2));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_start_ok) w_state_d = StLoadW;
      StLoadW:  if (w_last_w) w_state_d = StSwitch;
      StSwitch: w_state_d = StStream;
      StStream: if (w_last_x) w_state_d = StDrain;
      StDrain:  if (w_drain_end) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_wcnt    <= '0;
      r_vcnt    <= '0;
      r_num_vec <= '0;
      r_dcnt    <= '0;
      r_done    <= 1'b0;
      r_vchain  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_done   <= w_drain_end;
      // Bit k holds a row-0 issue from k+1 cycles ago; column c reads bit N+c-1.
      r_vchain <= {r_vchain[2*ARRAY_N-3:0], w_x_hs};
      if (w_start_ok) begin
        r_num_vec <= i_num_vec;
        r_wcnt    <= '0;
        r_vcnt    <= '0;
        r_dcnt    <= '0;
      end
      if (w_w_hs) r_wcnt <= r_wcnt + WCntW'(1);
      if (w_x_hs) r_vcnt <= r_vcnt + VEC_W'(1);
      if (r_state == StDrain) r_dcnt <= r_dcnt + DCntW'(1);
    end
  end

  // Row 0 enters the array unskewed in the handshake cycle.
  assign o_arr_valid[0]              = w_x_hs;
  assign o_arr_input[DATA_WIDTH-1:0] = w_x_hs ? i_x_data[DATA_WIDTH-1:0] : '0;

  for (genvar r = 1; r < ARRAY_N; r++) begin : g_skew
    logic [DATA_WIDTH-1:0] r_d [r];
    logic [r-1:0]          r_v;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= '0;
        for (int k = 0; k < r; k++) r_d[k] <= '0;
      end else begin
        r_v[0] <= w_x_hs;
        r_d[0] <= w_x_hs ? i_x_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k < r; k++) begin
          r_v[k] <= r_v[k-1];
          r_d[k] <= r_d[k-1];
        end
      end
    end

    assign o_arr_valid[r]                          = r_v[r-1];
    assign o_arr_input[r*DATA_WIDTH +: DATA_WIDTH] = r_d[r-1];
  end

  assign o_busy         = (r_state != StIdle);
  assign o_done         = r_done;
  assign o_w_ready      = (r_state == StLoadW);
  assign o_x_ready      = (r_state == StStream);
  assign o_arr_enable   = (r_state != StIdle);
  assign o_arr_weight   = w_w_hs ? i_w_data : '0;
  assign o_arr_accept_w = {ARRAY_N{w_w_hs}};
  assign o_arr_switch   = {ARRAY_N{r_state == StSwitch}};
  assign o_res_valid    = r_vchain[2*ARRAY_N-2:ARRAY_N-1];

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: timeline-based job model checked every cycle, plus
// directed jobs with hand-computed cycle expectations and a randomized soak.
module tb_systolic_ctrl;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int VW = 8;
  localparam int RW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [VW-1:0] i_num_vec = '0;
  logic          i_w_valid = 1'b0;
  logic          i_x_valid = 1'b0;
  logic [RW-1:0] i_w_data = '0;
  logic [RW-1:0] i_x_data = '0;
  logic          o_busy, o_done, o_w_ready, o_x_ready, o_arr_enable;
  logic [RW-1:0] o_arr_weight, o_arr_input;
  logic [N-1:0]  o_arr_accept_w, o_arr_valid, o_arr_switch, o_res_valid;

  systolic_ctrl #(.ARRAY_N(N), .DATA_WIDTH(DW), .VEC_W(VW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_vec(i_num_vec),
    .o_busy(o_busy), .o_done(o_done),
    .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data),
    .i_x_valid(i_x_valid), .o_x_ready(o_x_ready), .i_x_data(i_x_data),
    .o_arr_enable(o_arr_enable), .o_arr_weight(o_arr_weight),
    .o_arr_accept_w(o_arr_accept_w), .o_arr_input(o_arr_input),
    .o_arr_valid(o_arr_valid), .o_arr_switch(o_arr_switch), .o_res_valid(o_res_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Model: a job is a timeline of handshake cycles; row r sees issue t at t+r,
  // column c reports it at t+N+c, done lands 2N cycles after the last issue.
  bit            m_act;
  int            m_nv, m_wcnt, m_vcnt, m_sw_cyc, m_done_cyc;
  bit            hv [64];
  bit [RW-1:0]   hd [64];

  always @(negedge clk) begin : cmp
    bit loading, switching, streaming, w_hs, x_hs, acc;
    bit [RW-1:0] e_in, tmp;
    bit [N-1:0]  e_v, e_res;
    if (rst) begin
      chk("rst_ctrl", RW'({o_busy, o_done, o_w_ready, o_x_ready, o_arr_enable}), '0);
      chk("rst_vec", RW'({o_arr_accept_w, o_arr_valid, o_arr_switch, o_res_valid}), '0);
      chk("rst_weight", o_arr_weight, '0);
      chk("rst_input", o_arr_input, '0);
      m_act = 0; m_wcnt = 0; m_vcnt = 0; m_nv = 0; m_sw_cyc = -1; m_done_cyc = -1;
      for (int i = 0; i < 64; i++) begin hv[i] = 0; hd[i] = '0; end
    end else begin
      loading   = m_act && (m_wcnt < N);
      switching = m_act && (m_sw_cyc == cyc);
      streaming = m_act && (m_sw_cyc >= 0) && (cyc > m_sw_cyc) && (m_vcnt < m_nv);
      w_hs = loading && i_w_valid;
      x_hs = streaming && i_x_valid;
      hv[cyc & 63] = x_hs;
      hd[cyc & 63] = x_hs ? i_x_data : '0;
      for (int r = 0; r < N; r++) begin
        e_v[r] = hv[(cyc - r) & 63];
        tmp = hd[(cyc - r) & 63];
        e_in[r*DW +: DW] = tmp[r*DW +: DW];
      end
      for (int c = 0; c < N; c++) e_res[c] = hv[(cyc - N - c) & 63];
      chk("busy", RW'(o_busy), RW'(m_act));
      chk("done", RW'(o_done), RW'(cyc == m_done_cyc));
      chk("w_ready", RW'(o_w_ready), RW'(loading));
      chk("x_ready", RW'(o_x_ready), RW'(streaming));
      chk("arr_enable", RW'(o_arr_enable), RW'(m_act));
      chk("arr_weight", o_arr_weight, w_hs ? i_w_data : '0);
      chk("arr_accept_w", RW'(o_arr_accept_w), RW'(w_hs ? {N{1'b1}} : {N{1'b0}}));
      chk("arr_switch", RW'(o_arr_switch), RW'(switching ? {N{1'b1}} : {N{1'b0}}));
      chk("arr_valid", RW'(o_arr_valid), RW'(e_v));
      chk("arr_input", o_arr_input, e_in);
      chk("res_valid", RW'(o_res_valid), RW'(e_res));
      acc = !m_act && i_start && (i_num_vec != 0);
      if (w_hs) begin
        m_wcnt++;
        if (m_wcnt == N) m_sw_cyc = cyc + 1;
      end
      if (x_hs) begin
        m_vcnt++;
        if (m_vcnt == m_nv) m_done_cyc = cyc + 2 * N;
      end
      if (m_act && (m_done_cyc == cyc + 1)) m_act = 0;
      if (acc) begin
        m_act = 1; m_nv = int'(i_num_vec); m_wcnt = 0; m_vcnt = 0;
        m_sw_cyc = -1; m_done_cyc = -1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    i_w_data = {$urandom(), $urandom()};
    i_x_data = {$urandom(), $urandom()};
  endtask

  // Launch a job at relative cycle 0; literal checks sample at posedge+4.
  task automatic launch(input int nv);
    tick();
    i_start = 1'b1; i_num_vec = VW'(nv); i_w_valid = 1'b1; i_x_valid = 1'b1;
    #3;
  endtask

  initial begin
    bit seen;
    tick(); tick();
    rst = 1'b0;

    // Single-vector job, all inputs valid.
    launch(1);
    chk("t2_busy_rel0", RW'(o_busy), RW'(0));
    for (int rel = 1; rel <= 15; rel++) begin
      tick(); i_start = 1'b0; #3;
      case (rel)
        1:  begin chk("t2_accept_r1", RW'(o_arr_accept_w), RW'(4'hF));
                  chk("t2_busy_r1", RW'(o_busy), RW'(1)); end
        4:  chk("t2_accept_r4", RW'(o_arr_accept_w), RW'(4'hF));
        5:  begin chk("t2_switch_r5", RW'(o_arr_switch), RW'(4'hF));
                  chk("t2_wready_r5", RW'(o_w_ready), RW'(0)); end
        6:  chk("t2_valid_r6", RW'(o_arr_valid), RW'(4'b0001));
        7:  begin chk("t2_valid_r7", RW'(o_arr_valid), RW'(4'b0010));
                  chk("t2_xready_r7", RW'(o_x_ready), RW'(0)); end
        9:  chk("t2_valid_r9", RW'(o_arr_valid), RW'(4'b1000));
        10: chk("t2_res_r10", RW'(o_res_valid), RW'(4'b0001));
        13: begin chk("t2_res_r13", RW'(o_res_valid), RW'(4'b1000));
                  chk("t2_done_r13", RW'(o_done), RW'(0)); end
        14: begin chk("t2_done_r14", RW'(o_done), RW'(1));
                  chk("t2_busy_r14", RW'(o_busy), RW'(0)); end
        15: chk("t2_done_r15", RW'(o_done), RW'(0));
        default: ;
      endcase
    end

    // Weight stall for two cycles mid-load.
    launch(1);
    for (int rel = 1; rel <= 16; rel++) begin
      tick(); i_start = 1'b0; i_w_valid = !(rel == 2 || rel == 3); #3;
      case (rel)
        2: chk("t3_accept_r2", RW'(o_arr_accept_w), RW'(0));
        3: chk("t3_accept_r3", RW'(o_arr_accept_w), RW'(0));
        6: begin chk("t3_switch_r6", RW'(o_arr_switch), RW'(0));
                 chk("t3_accept_r6", RW'(o_arr_accept_w), RW'(4'hF)); end
        7: chk("t3_switch_r7", RW'(o_arr_switch), RW'(4'hF));
        8: chk("t3_valid_r8", RW'(o_arr_valid), RW'(4'b0001));
        16: chk("t3_done_r16", RW'(o_done), RW'(1));
        default: ;
      endcase
    end

    // Three vectors with an input bubble; row 2 shows the pattern two cycles late.
    launch(3);
    for (int rel = 1; rel <= 17; rel++) begin
      tick(); i_start = 1'b0;
      i_x_valid = (rel < 6) || rel == 6 || rel == 8 || rel == 9; #3;
      case (rel)
        7:  chk("t4_row2_r7", RW'(o_arr_valid[2]), RW'(0));
        8:  chk("t4_row2_r8", RW'(o_arr_valid[2]), RW'(1));
        9:  chk("t4_row2_r9", RW'(o_arr_valid[2]), RW'(0));
        10: chk("t4_row2_r10", RW'(o_arr_valid[2]), RW'(1));
        11: chk("t4_row2_r11", RW'(o_arr_valid[2]), RW'(1));
        12: chk("t4_row2_r12", RW'(o_arr_valid[2]), RW'(0));
        16: chk("t4_busy_r16", RW'(o_busy), RW'(1));
        17: chk("t4_done_r17", RW'(o_done), RW'(1));
        default: ;
      endcase
    end

    // Zero-length start and a start while busy are both ignored.
    tick(); i_start = 1'b1; i_num_vec = '0;
    tick(); i_start = 1'b0; #3;
    chk("t5_nv0_busy", RW'(o_busy), RW'(0));
    launch(2);
    for (int rel = 1; rel <= 15; rel++) begin
      tick();
      i_start = (rel == 3);
      if (rel == 3) i_num_vec = VW'(7);
      #3;
      case (rel)
        4:  chk("t5_busy_r4", RW'(o_busy), RW'(1));
        14: chk("t5_done_r14", RW'(o_done), RW'(0));
        15: chk("t5_done_r15", RW'(o_done), RW'(1));
        default: ;
      endcase
    end

    // Back-to-back: start the cycle after done.
    launch(1);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(); i_start = 1'b0; #3;
      seen = o_done;
    end
    if (!seen) chk("t6_done_timeout", RW'(0), RW'(1));
    tick(); i_start = 1'b1; i_num_vec = VW'(2);
    tick(); i_start = 1'b0; #3;
    chk("t6_second_busy", RW'(o_busy), RW'(1));
    for (int i = 0; i < 20; i++) tick();

    // Reset in the middle of streaming.
    launch(20);
    for (int rel = 1; rel <= 8; rel++) begin tick(); i_start = 1'b0; end
    #3;
    chk("t1_pre_valid", RW'(o_arr_valid != 0), RW'(1));
    tick(); rst = 1'b1; #3;
    chk("t1_rst_busy", RW'({o_busy, o_arr_enable, o_x_ready}), RW'(0));
    chk("t1_rst_valid", RW'(o_arr_valid), RW'(0));
    tick(); tick(); rst = 1'b0; #3;
    chk("t1_post_busy", RW'(o_busy), RW'(0));
    tick(); #3;
    chk("t1_post_xready", RW'(o_x_ready), RW'(0));

    // Randomized soak.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst       = ($urandom_range(0, 499) == 0);
      i_w_valid = ($urandom_range(0, 3) != 0);
      i_x_valid = ($urandom_range(0, 3) != 0);
      i_start   = ($urandom_range(0, 7) == 0);
      i_num_vec = VW'($urandom_range(0, 6));
    end
    tick(); rst = 1'b0; i_start = 1'b0;
    for (int i = 0; i < 30; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
